// File: rtl/ddr3_reset_n_seq_if.sv
// DDR3 RESET_N sequencer bundle: controller-side control
// plus the RESET_N IOD lane and delay-line handshake.
interface ddr3_reset_n_seq_if;
    logic       START;
    logic       RESET_REQ;
    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       ODT_EN_0;
    logic       CKE_READY;
    logic       BUSY;
    logic       DLY_ADJ_REQ;
    logic       DLY_ADJ_DIR;
    logic       DLY_ADJ_ACK;
    logic       DLY_ERR;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       DELAY_LINE_OUT_OF_RANGE_0;

    modport slave (
        input  START,
        input  RESET_REQ,
        input  DLY_ADJ_REQ,
        input  DLY_ADJ_DIR,
        input  DELAY_LINE_OUT_OF_RANGE_0,
        output TX_DATA_0,
        output OE_DATA_0,
        output ODT_EN_0,
        output CKE_READY,
        output BUSY,
        output DLY_ADJ_ACK,
        output DLY_ERR,
        output DELAY_LINE_LOAD_0,
        output DELAY_LINE_MOVE_0,
        output DELAY_LINE_DIRECTION_0
    );

    modport master (
        output START,
        output RESET_REQ,
        output DLY_ADJ_REQ,
        output DLY_ADJ_DIR,
        output DELAY_LINE_OUT_OF_RANGE_0,
        input  TX_DATA_0,
        input  OE_DATA_0,
        input  ODT_EN_0,
        input  CKE_READY,
        input  BUSY,
        input  DLY_ADJ_ACK,
        input  DLY_ERR,
        input  DELAY_LINE_LOAD_0,
        input  DELAY_LINE_MOVE_0,
        input  DELAY_LINE_DIRECTION_0
    );
endinterface

// File: rtl/ddr3_reset_n_seq.sv
// DDR3 RESET_N power-up/re-reset sequencer and RESET_N IOD
// delay-line step engine, all outputs registered on FAB_CLK.
module ddr3_reset_n_seq #(
    parameter int RST_LOW_CYCLES  = 40000,
    parameter int CKE_WAIT_CYCLES = 100000,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic FAB_CLK,
    input  logic ARST_N,
    ddr3_reset_n_seq_if.slave bus
);

    localparam int MAXC = (RST_LOW_CYCLES > CKE_WAIT_CYCLES) ?
                          RST_LOW_CYCLES : CKE_WAIT_CYCLES;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] R_LAST = CW'(RST_LOW_CYCLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CKE_WAIT_CYCLES - 1);
    localparam logic [3:0]    S_LAST = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE, S_ASSERT, S_RELEASE, S_DONE
    } seq_e;

    typedef enum logic [2:0] {
        D_LOAD, D_IDLE, D_DIR, D_MOVE, D_SETTLE
    } dly_e;

    seq_e          seq_q, seq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    tx_q, tx_d;
    logic          cke_q, cke_d;
    logic          busy_q, busy_d;

    dly_e          dly_q, dly_d;
    logic [3:0]    scnt_q, scnt_d;
    logic          dir_q, dir_d;
    logic          load_q, load_d;
    logic          move_q, move_d;
    logic          ack_q, ack_d;
    logic          oor_q, oor_d;
    logic          err_q, err_d;

    always_comb begin
        seq_d = seq_q;
        cnt_d = cnt_q;
        unique case (seq_q)
            S_IDLE: begin
                if (bus.START) begin
                    seq_d = S_ASSERT;
                    cnt_d = '0;
                end
            end
            S_ASSERT: begin
                if (cnt_q == R_LAST) begin
                    seq_d = S_RELEASE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RELEASE: begin
                if (cnt_q == C_LAST) begin
                    seq_d = S_DONE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.RESET_REQ) begin
                    seq_d = S_ASSERT;
                    cnt_d = '0;
                end
            end
        endcase
        // Lane outputs trail the state register by one edge
        tx_d   = {4{(seq_q == S_RELEASE) || (seq_q == S_DONE)}};
        cke_d  = (seq_q == S_DONE);
        busy_d = (seq_q == S_ASSERT) || (seq_q == S_RELEASE);
    end

    always_comb begin
        dly_d  = dly_q;
        scnt_d = scnt_q;
        dir_d  = dir_q;
        load_d = 1'b0;
        move_d = 1'b0;
        ack_d  = 1'b0;
        oor_d  = 1'b0;
        err_d  = err_q | oor_q;
        unique case (dly_q)
            D_LOAD: begin
                load_d = 1'b1;
                dly_d  = D_IDLE;
            end
            D_IDLE: begin
                if (bus.DLY_ADJ_REQ) begin
                    dir_d = bus.DLY_ADJ_DIR;
                    dly_d = D_DIR;
                end
            end
            D_DIR: begin
                dly_d = D_MOVE;
            end
            D_MOVE: begin
                move_d = 1'b1;
                scnt_d = '0;
                dly_d  = D_SETTLE;
            end
            D_SETTLE: begin
                if (scnt_q == S_LAST) begin
                    ack_d = 1'b1;
                    oor_d = bus.DELAY_LINE_OUT_OF_RANGE_0;
                    dly_d = D_IDLE;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            default: begin
                dly_d = D_IDLE;
            end
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            seq_q  <= S_IDLE;
            cnt_q  <= '0;
            tx_q   <= 4'b0000;
            cke_q  <= 1'b0;
            busy_q <= 1'b0;
            dly_q  <= D_LOAD;
            scnt_q <= '0;
            dir_q  <= 1'b0;
            load_q <= 1'b0;
            move_q <= 1'b0;
            ack_q  <= 1'b0;
            oor_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            cnt_q  <= cnt_d;
            tx_q   <= tx_d;
            cke_q  <= cke_d;
            busy_q <= busy_d;
            dly_q  <= dly_d;
            scnt_q <= scnt_d;
            dir_q  <= dir_d;
            load_q <= load_d;
            move_q <= move_d;
            ack_q  <= ack_d;
            oor_q  <= oor_d;
            err_q  <= err_d;
        end
    end

    assign bus.TX_DATA_0              = tx_q;
    assign bus.OE_DATA_0              = 4'b1111;
    assign bus.ODT_EN_0               = 1'b0;
    assign bus.CKE_READY              = cke_q;
    assign bus.BUSY                   = busy_q;
    assign bus.DLY_ADJ_ACK            = ack_q;
    assign bus.DLY_ERR                = err_q;
    assign bus.DELAY_LINE_LOAD_0      = load_q;
    assign bus.DELAY_LINE_MOVE_0      = move_q;
    assign bus.DELAY_LINE_DIRECTION_0 = dir_q;

endmodule

// File: tb/tb_ddr3_reset_n_seq.sv
// Scoreboard bench for ddr3_reset_n_seq: expected output
// events are queued per kind and matched by a cycle monitor.
module tb_ddr3_reset_n_seq;

    localparam int K_LOAD = 0;
    localparam int K_MOVE = 1;
    localparam int K_ACK  = 2;
    localparam int K_TXR  = 3;
    localparam int K_TXF  = 4;
    localparam int K_CKR  = 5;
    localparam int K_CKF  = 6;
    localparam int K_BSR  = 7;
    localparam int K_BSF  = 8;
    localparam int K_ERR  = 9;
    localparam int K_ERF  = 10;
    localparam int NK     = 11;

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t exp_q [NK][$];

    ddr3_reset_n_seq_if bus ();

    ddr3_reset_n_seq #(
        .RST_LOW_CYCLES  (10),
        .CKE_WAIT_CYCLES (20),
        .SETTLE_CYCLES   (2)
    ) dut (
        .FAB_CLK (clk),
        .ARST_N  (arst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic string kname(int k);
        case (k)
            K_LOAD:  return "load_pulse";
            K_MOVE:  return "move_pulse";
            K_ACK:   return "ack_pulse";
            K_TXR:   return "tx_rise";
            K_TXF:   return "tx_fall";
            K_CKR:   return "cke_rise";
            K_CKF:   return "cke_fall";
            K_BSR:   return "busy_rise";
            K_BSF:   return "busy_fall";
            K_ERR:   return "err_rise";
            default: return "err_fall";
        endcase
    endfunction

    task automatic push(int k, int c, logic v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        exp_q[k].push_back(e);
    endtask

    task automatic chk(string nm, logic [31:0] act,
                       logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h",
                     nm, act, req);
        end
    endtask

    task automatic ev(int k, int c, logic v);
        exp_t e;
        n_chk++;
        if (exp_q[k].size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected at cycle %0d",
                     kname(k), c);
        end else begin
            e = exp_q[k].pop_front();
            if (e.cyc != c || e.val !== v) begin
                n_fail++;
                $display("FAIL %s: got cycle %0d val %b, expected cycle %0d val %b",
                         kname(k), c, v, e.cyc, e.val);
            end
        end
    endtask

    // Monitor: samples #1 after each edge, turns output
    // activity into events and matches them to the queues.
    initial begin
        logic tx_p, ck_p, bs_p, er_p;
        logic tx_h;
        int   c;
        tx_p = 1'b0;
        ck_p = 1'b0;
        bs_p = 1'b0;
        er_p = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tx_h = (bus.TX_DATA_0 == 4'hF);
            if (!arst_n) begin
                cyc = 0;
            end else begin
                c = cyc;
                if (bus.DELAY_LINE_LOAD_0)
                    ev(K_LOAD, c, 1'b0);
                if (bus.DELAY_LINE_MOVE_0)
                    ev(K_MOVE, c, bus.DELAY_LINE_DIRECTION_0);
                if (bus.DLY_ADJ_ACK)
                    ev(K_ACK, c, bus.DELAY_LINE_DIRECTION_0);
                if (tx_h != tx_p)
                    chk("tx_uniform",
                        32'(bus.TX_DATA_0 == 4'h0 || tx_h), 1);
                if (tx_h && !tx_p) ev(K_TXR, c, 1'b0);
                if (!tx_h && tx_p) ev(K_TXF, c, 1'b0);
                if (bus.CKE_READY && !ck_p) ev(K_CKR, c, 1'b0);
                if (!bus.CKE_READY && ck_p) ev(K_CKF, c, 1'b0);
                if (bus.BUSY && !bs_p) ev(K_BSR, c, 1'b0);
                if (!bus.BUSY && bs_p) ev(K_BSF, c, 1'b0);
                if (bus.DLY_ERR && !er_p) ev(K_ERR, c, 1'b0);
                if (!bus.DLY_ERR && er_p) ev(K_ERF, c, 1'b0);
                cyc = c + 1;
            end
            tx_p = tx_h;
            ck_p = bus.CKE_READY;
            bs_p = bus.BUSY;
            er_p = bus.DLY_ERR;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached at cycle %0d",
                 cyc);
        $fatal(1, "timeout");
    end

    task automatic go_to(int c);
        while (cyc != c) @(negedge clk);
    endtask

    task automatic dly_req(int c, logic d);
        go_to(c);
        bus.DLY_ADJ_REQ = 1'b1;
        bus.DLY_ADJ_DIR = d;
        @(negedge clk);
        bus.DLY_ADJ_REQ = 1'b0;
    endtask

    task automatic rst_checks(string tag);
        chk({tag, "_tx"},   32'(bus.TX_DATA_0), 0);
        chk({tag, "_oe"},   32'(bus.OE_DATA_0), 32'hF);
        chk({tag, "_odt"},  32'(bus.ODT_EN_0), 0);
        chk({tag, "_cke"},  32'(bus.CKE_READY), 0);
        chk({tag, "_busy"}, 32'(bus.BUSY), 0);
        chk({tag, "_ack"},  32'(bus.DLY_ADJ_ACK), 0);
        chk({tag, "_err"},  32'(bus.DLY_ERR), 0);
        chk({tag, "_move"}, 32'(bus.DELAY_LINE_MOVE_0), 0);
        chk({tag, "_dir"},  32'(bus.DELAY_LINE_DIRECTION_0), 0);
        chk({tag, "_load"}, 32'(bus.DELAY_LINE_LOAD_0), 0);
    endtask

    initial begin
        bus.START = 1'b0;
        bus.RESET_REQ = 1'b0;
        bus.DLY_ADJ_REQ = 1'b0;
        bus.DLY_ADJ_DIR = 1'b0;
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        #1 arst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_checks("reset");

        // Power-up: START at 5, R=10, C=20
        push(K_LOAD, 0, 1'b0);
        push(K_BSR, 6, 1'b0);
        push(K_TXR, 16, 1'b0);
        push(K_BSF, 36, 1'b0);
        push(K_CKR, 36, 1'b0);
        arst_n = 1'b1;
        go_to(5);
        bus.START = 1'b1;
        go_to(25);
        bus.RESET_REQ = 1'b1;
        @(negedge clk);
        bus.RESET_REQ = 1'b0;
        go_to(40);
        bus.START = 1'b0;

        // In-range step up; REQ at 52 lands in D_MOVE
        push(K_MOVE, 52, 1'b1);
        push(K_ACK, 55, 1'b1);
        dly_req(50, 1'b1);
        go_to(52);
        chk("dir_after_req", 32'(bus.DELAY_LINE_DIRECTION_0), 1);
        dly_req(52, 1'b0);

        // Out-of-range step down
        push(K_MOVE, 62, 1'b0);
        push(K_ACK, 65, 1'b0);
        push(K_ERR, 66, 1'b0);
        dly_req(60, 1'b0);
        go_to(63);
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
        go_to(66);
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

        // Second in-range step with DLY_ERR already set
        push(K_MOVE, 72, 1'b1);
        push(K_ACK, 75, 1'b1);
        dly_req(70, 1'b1);

        // Re-reset from DONE; START during ASSERT ignored
        push(K_TXF, 81, 1'b0);
        push(K_CKF, 81, 1'b0);
        push(K_BSR, 81, 1'b0);
        push(K_TXR, 91, 1'b0);
        go_to(80);
        chk("err_sticky", 32'(bus.DLY_ERR), 1);
        bus.RESET_REQ = 1'b1;
        @(negedge clk);
        bus.RESET_REQ = 1'b0;
        go_to(85);
        bus.START = 1'b1;
        go_to(88);
        bus.START = 1'b0;

        // Async reset in RELEASE_WAIT with MOVE high
        push(K_MOVE, 97, 1'b1);
        dly_req(95, 1'b1);
        go_to(98);
        chk("move_before_arst",
            32'(bus.DELAY_LINE_MOVE_0), 1);
        arst_n = 1'b0;
        #1;
        rst_checks("arst");

        push(K_LOAD, 0, 1'b0);
        push(K_BSR, 4, 1'b0);
        push(K_TXR, 14, 1'b0);
        push(K_BSF, 34, 1'b0);
        push(K_CKR, 34, 1'b0);
        repeat (3) @(negedge clk);
        arst_n = 1'b1;
        go_to(2);
        chk("idle_tx_low", 32'(bus.TX_DATA_0), 0);
        go_to(3);
        bus.START = 1'b1;
        go_to(6);
        bus.START = 1'b0;
        go_to(45);

        for (int k = 0; k < NK; k++) begin
            while (exp_q[k].size() > 0) begin
                exp_t e;
                e = exp_q[k].pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL %s: missing, expected at cycle %0d",
                         kname(k), e.cyc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
